// File: rtl/cache_pkg.sv
// Shared types and constants for the cache miss/fill controller.
// Holds FSM state encodings, owner encodings, block geometry and the
// word-address helper used by both the issue and return paths.
package cache_pkg;

  localparam int          WORDS_PER_BLOCK = 8;
  localparam logic [15:0] BLOCK_MASK      = 16'hFFF0;

  typedef enum logic [1:0] {
    FILL_IDLE = 2'd0,
    FILL_FILL = 2'd1,
    FILL_TAG  = 2'd2
  } fill_state_e;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_e;

  // Byte address of word idx inside a block-aligned base (2 bytes per word).
  function automatic logic [15:0] word_addr(input logic [15:0] base,
                                            input logic [3:0]  idx);
    return base + {11'd0, idx, 1'b0};
  endfunction

endpackage

// File: rtl/fill_arbiter.sv
// D-over-I miss arbiter. The grant is combinational so the FSM can leave
// IDLE in the same cycle a miss is seen; the winning owner is registered
// and held for the whole fill.
module fill_arbiter
  import cache_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        grant_en_i,
  input  logic        i_miss_i,
  input  logic [15:0] i_addr_i,
  input  logic        d_miss_i,
  input  logic [15:0] d_addr_i,
  output logic        grant_o,
  output logic [15:0] grant_base_o,
  output owner_e      owner_o
);

  owner_e owner_q, owner_d;

  // Priority select: the D-cache wins when both caches miss together.
  always_comb begin
    grant_o      = grant_en_i & (i_miss_i | d_miss_i);
    grant_base_o = (d_miss_i ? d_addr_i : i_addr_i) & BLOCK_MASK;
    owner_d      = owner_q;
    if (grant_o) owner_d = d_miss_i ? OWN_D : OWN_I;
  end

  // Owner latch, updated only on a grant.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) owner_q <= OWN_I;
    else     owner_q <= owner_d;
  end

  assign owner_o = owner_q;

endmodule

// File: rtl/cache_fill_ctrl.sv
// Cache fill controller: grants one I/D miss at a time, issues an 8-word
// read burst to the shared 16-bit memory, steers returned words into the
// owning cache, then strobes the tag write that releases the miss.
// Optional feature macro: CACHE_FILL_STATS_EN adds per-cache fill counters.
module cache_fill_ctrl
  import cache_pkg::*;
#(
  parameter int MEM_LAT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_miss,
  input  logic [15:0] i_miss_addr,
  input  logic        d_miss,
  input  logic [15:0] d_miss_addr,
  input  logic [15:0] mem_data_out,
  input  logic        mem_data_valid,
  output logic        mem_enable,
  output logic [15:0] mem_addr,
  output logic [15:0] fill_data,
  output logic [15:0] fill_addr,
  output logic        i_load_data,
  output logic        d_load_data,
  output logic        i_load_tag,
  output logic        d_load_tag,
`ifdef CACHE_FILL_STATS_EN
  output logic [15:0] i_fill_count,
  output logic [15:0] d_fill_count,
`endif
  output logic        i_fill_busy,
  output logic        d_fill_busy
);

  localparam logic [3:0] WPB      = 4'(WORDS_PER_BLOCK);
  localparam logic [2:0] LAST_RCV = 3'(WORDS_PER_BLOCK - 1);

  // The controller only counts returns; a zero-latency memory cannot
  // overlap issue and return the way the burst relies on.
  if (MEM_LAT < 1) begin : g_lat_chk
    $error("MEM_LAT must be at least 1");
  end

  fill_state_e state_q, state_d;
  logic [15:0] base_q, base_d;
  logic [3:0]  issue_cnt_q, issue_cnt_d;
  logic [2:0]  rcv_cnt_q, rcv_cnt_d;

  logic        grant;
  logic [15:0] grant_base;
  owner_e      owner;
  logic        load_data;
  logic        load_tag;

  fill_arbiter u_arb (
    .clk          (clk),
    .rst          (rst),
    .grant_en_i   (state_q == FILL_IDLE),
    .i_miss_i     (i_miss),
    .i_addr_i     (i_miss_addr),
    .d_miss_i     (d_miss),
    .d_addr_i     (d_miss_addr),
    .grant_o      (grant),
    .grant_base_o (grant_base),
    .owner_o      (owner)
  );

  // Next-state and burst control; issue and return paths run independently
  // inside FILL so they overlap once the first read comes back.
  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    issue_cnt_d = issue_cnt_q;
    rcv_cnt_d   = rcv_cnt_q;
    mem_enable  = 1'b0;
    mem_addr    = '0;
    fill_addr   = '0;
    load_data   = 1'b0;
    load_tag    = 1'b0;
    case (state_q)
      FILL_IDLE: begin
        if (grant) begin
          base_d      = grant_base;
          issue_cnt_d = '0;
          rcv_cnt_d   = '0;
          state_d     = FILL_FILL;
        end
      end
      FILL_FILL: begin
        if (issue_cnt_q < WPB) begin
          mem_enable  = 1'b1;
          mem_addr    = word_addr(base_q, issue_cnt_q);
          issue_cnt_d = issue_cnt_q + 4'd1;
        end
        if (mem_data_valid) begin
          load_data = 1'b1;
          fill_addr = word_addr(base_q, {1'b0, rcv_cnt_q});
          rcv_cnt_d = rcv_cnt_q + 3'd1;
          if (rcv_cnt_q == LAST_RCV) state_d = FILL_TAG;
        end
      end
      FILL_TAG: begin
        load_tag  = 1'b1;
        fill_addr = base_q;
        state_d   = FILL_IDLE;
      end
      default: state_d = FILL_IDLE;
    endcase
  end

  // State, block base and burst counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= FILL_IDLE;
      base_q      <= '0;
      issue_cnt_q <= '0;
      rcv_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      issue_cnt_q <= issue_cnt_d;
      rcv_cnt_q   <= rcv_cnt_d;
    end
  end

  assign fill_data   = mem_data_out;
  assign i_load_data = load_data & (owner == OWN_I);
  assign d_load_data = load_data & (owner == OWN_D);
  assign i_load_tag  = load_tag  & (owner == OWN_I);
  assign d_load_tag  = load_tag  & (owner == OWN_D);
  assign i_fill_busy = (state_q != FILL_IDLE) & (owner == OWN_I);
  assign d_fill_busy = (state_q != FILL_IDLE) & (owner == OWN_D);

`ifdef CACHE_FILL_STATS_EN
  logic [15:0] i_cnt_q, i_cnt_d;
  logic [15:0] d_cnt_q, d_cnt_d;

  // A completed fill is the tag write; counters wrap naturally.
  always_comb begin
    i_cnt_d = i_cnt_q;
    d_cnt_d = d_cnt_q;
    if (i_load_tag) i_cnt_d = i_cnt_q + 16'd1;
    if (d_load_tag) d_cnt_d = d_cnt_q + 16'd1;
  end

  // Fill statistics registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      i_cnt_q <= '0;
      d_cnt_q <= '0;
    end else begin
      i_cnt_q <= i_cnt_d;
      d_cnt_q <= d_cnt_d;
    end
  end

  assign i_fill_count = i_cnt_q;
  assign d_fill_count = d_cnt_q;
`endif

endmodule
